sme_ctrl: RTL and testbench

SME_CTRL -- requirements
Module: sme_ctrl

---
 rtl/sme_pkg.sv | 23 ++
 rtl/sme_ctrl.sv | 152 +++++++++++++++
 tb/tb_sme_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sme_pkg.sv
// Shared definitions for the string-matching engine: controller state codes,
// special pattern characters and the string/pattern capacity limits.
package sme_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_STR = 3'd1,
    LOAD_PAT = 3'd2,
    COMP     = 3'd3,
    OUT      = 3'd4
  } sme_state_e;

  localparam logic [7:0] HEAD  = 8'h5E;
  localparam logic [7:0] TAIL  = 8'h24;
  localparam logic [7:0] DOT   = 8'h2E;
  localparam logic [7:0] SPACE = 8'h20;

  localparam int STR_MAX   = 32;
  localparam int PAT_MAX   = 10;
  localparam int STR_BYTES = STR_MAX + 2;
  localparam int PAT_BYTES = PAT_MAX;

endpackage

// File: rtl/sme_ctrl.sv
// Controller for the string-matching engine: collects string and pattern
// characters from the host, hands them to the comparator and returns its result.
module sme_ctrl
  import sme_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               chardata,
  input  logic                     isstring,
  input  logic                     ispattern,
  input  logic                     comp_ready,
  input  logic                     comp_match,
  input  logic [4:0]               comp_index,
  output logic [8*STR_BYTES-1:0]   str_reg_w,
  output logic [8*PAT_BYTES-1:0]   pat_reg_w,
  output logic [5:0]               str_len,
  output logic [3:0]               pat_len,
  output logic [2:0]               c_state,
  output logic                     valid,
  output logic                     match,
  output logic [4:0]               match_index,
  output logic                     busy,
  output logic                     ovf
);

  sme_state_e               state_q, state_d;
  logic [8*STR_BYTES-1:0]   str_reg_q, str_reg_d;
  logic [8*PAT_BYTES-1:0]   pat_reg_q, pat_reg_d;
  logic [5:0]               str_len_q, str_len_d;
  logic [3:0]               pat_len_q, pat_len_d;
  logic                     valid_q, valid_d;
  logic                     match_q, match_d;
  logic [4:0]               match_index_q, match_index_d;
  logic                     ovf_q, ovf_d;
  logic [3:0]               pat_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      str_reg_q     <= '0;
      pat_reg_q     <= '0;
      str_len_q     <= '0;
      pat_len_q     <= '0;
      valid_q       <= 1'b0;
      match_q       <= 1'b0;
      match_index_q <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      str_reg_q     <= str_reg_d;
      pat_reg_q     <= pat_reg_d;
      str_len_q     <= str_len_d;
      pat_len_q     <= pat_len_d;
      valid_q       <= valid_d;
      match_q       <= match_d;
      match_index_q <= match_index_d;
      ovf_q         <= ovf_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    str_reg_d     = str_reg_q;
    pat_reg_d     = pat_reg_q;
    str_len_d     = str_len_q;
    pat_len_d     = pat_len_q;
    valid_d       = 1'b0;
    match_d       = 1'b0;
    match_index_d = '0;
    ovf_d         = ovf_q;
    // Pattern characters fill from the top byte downwards.
    pat_idx       = 4'(PAT_MAX - 1) - pat_len_q;

    unique case (state_q)
      IDLE: begin
        if (isstring) begin
          str_reg_d        = '0;
          str_reg_d[23:0]  = {SPACE, chardata, SPACE};
          str_len_d        = 6'd1;
          ovf_d            = 1'b0;
          state_d          = LOAD_STR;
        end else if (ispattern) begin
          pat_reg_d        = '0;
          pat_reg_d[8*PAT_BYTES-1 -: 8] = chardata;
          pat_len_d        = 4'd1;
          state_d          = LOAD_PAT;
        end
      end

      LOAD_STR: begin
        // isstring keeps priority here too, matching the IDLE decode.
        if (isstring) begin
          if (str_len_q < 6'(STR_MAX)) begin
            str_reg_d = {str_reg_q[8*STR_MAX+7:8], chardata, SPACE};
            str_len_d = str_len_q + 6'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (ispattern) begin
          pat_reg_d        = '0;
          pat_reg_d[8*PAT_BYTES-1 -: 8] = chardata;
          pat_len_d        = 4'd1;
          state_d          = LOAD_PAT;
        end else begin
          state_d = IDLE;
        end
      end

      LOAD_PAT: begin
        if (ispattern) begin
          if (pat_len_q < 4'(PAT_MAX)) begin
            pat_reg_d[8*pat_idx +: 8] = chardata;
            pat_len_d = pat_len_q + 4'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          state_d = COMP;
        end
      end

      COMP: begin
        if (comp_ready) begin
          valid_d       = 1'b1;
          match_d       = comp_match;
          match_index_d = comp_match ? comp_index : 5'd0;
          state_d       = OUT;
        end
      end

      OUT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign str_reg_w   = str_reg_q;
  assign pat_reg_w   = pat_reg_q;
  assign str_len     = str_len_q;
  assign pat_len     = pat_len_q;
  assign c_state     = state_q;
  assign valid       = valid_q;
  assign match       = match_q;
  assign match_index = match_index_q;
  assign ovf         = ovf_q;
  assign busy        = (state_q == COMP) || (state_q == OUT);

endmodule

// File: tb/tb_sme_ctrl.sv
// Self-checking bench for sme_ctrl: table-driven load sequence, scoreboarded
// comparator results, overflow limits and reset during a compare.
module tb_sme_ctrl;

  logic         clk;
  logic         reset;
  logic [7:0]   chardata;
  logic         isstring;
  logic         ispattern;
  logic         comp_ready;
  logic         comp_match;
  logic [4:0]   comp_index;
  logic [271:0] str_reg_w;
  logic [79:0]  pat_reg_w;
  logic [5:0]   str_len;
  logic [3:0]   pat_len;
  logic [2:0]   c_state;
  logic         valid;
  logic         match;
  logic [4:0]   match_index;
  logic         busy;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int valid_count = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic       match;
    logic [4:0] index;
  } result_t;

  result_t exp_q[$];

  typedef struct {
    logic       is_str;
    logic       is_pat;
    logic [7:0] ch;
    logic [2:0] exp_state;
    logic [5:0] exp_str_len;
    logic [3:0] exp_pat_len;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[5];

  sme_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .comp_ready  (comp_ready),
    .comp_match  (comp_match),
    .comp_index  (comp_index),
    .str_reg_w   (str_reg_w),
    .pat_reg_w   (pat_reg_w),
    .str_len     (str_len),
    .pat_len     (pat_len),
    .c_state     (c_state),
    .valid       (valid),
    .match       (match),
    .match_index (match_index),
    .busy        (busy),
    .ovf         (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [271:0] actual, input logic [271:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic [7:0] c);
    isstring  = s;
    ispattern = p;
    chardata  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState();
    checkOutput("rst_state", c_state, 0);
    checkOutput("rst_str", str_reg_w, 0);
    checkOutput("rst_pat", pat_reg_w, 0);
    checkOutput("rst_str_len", str_len, 0);
    checkOutput("rst_pat_len", pat_len, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_match", match, 0);
    checkOutput("rst_match_index", match_index, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ovf", ovf, 0);
  endtask

  // Result monitor: every valid pulse must match the oldest queued expectation,
  // last one cycle only, and the result outputs must be zero otherwise.
  always @(negedge clk) begin
    result_t e;
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: got valid=1 expected no pending result");
      end else begin
        e = exp_q.pop_front();
        checkOutput("match", match, e.match);
        checkOutput("match_index", match_index, e.index);
      end
      checkOutput("valid_width", prev_valid, 0);
      valid_count++;
    end else begin
      checkOutput("quiet_result", {match, match_index}, 0);
    end
    prev_valid = valid;
  end

  initial begin
    logic [271:0] str_abc;
    logic [271:0] exp_str;
    logic [79:0]  exp_pat;
    logic [79:0]  pat_b;

    reset      = 1'b1;
    isstring   = 1'b0;
    ispattern  = 1'b0;
    chardata   = 8'h00;
    comp_ready = 1'b0;
    comp_match = 1'b0;
    comp_index = 5'd0;

    vecs[0] = '{1'b1, 1'b0, 8'h61, 3'd1, 6'd1, 4'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h62, 3'd1, 6'd2, 4'd0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h63, 3'd1, 6'd3, 4'd0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h62, 3'd2, 6'd3, 4'd1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 3'd3, 6'd3, 4'd1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    checkResetState();
    reset = 1'b0;

    // String "abc" then pattern "b"
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].is_str, vecs[i].is_pat, vecs[i].ch);
      checkOutput($sformatf("vec%0d_state", i), c_state, vecs[i].exp_state);
      checkOutput($sformatf("vec%0d_str_len", i), str_len, vecs[i].exp_str_len);
      checkOutput($sformatf("vec%0d_pat_len", i), pat_len, vecs[i].exp_pat_len);
      checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
    end

    str_abc = '0;
    str_abc[39:0] = {8'h20, 8'h61, 8'h62, 8'h63, 8'h20};
    pat_b = '0;
    pat_b[79:72] = 8'h62;
    checkOutput("abc_str", str_reg_w, str_abc);
    checkOutput("abc_pat", pat_reg_w, pat_b);

    // Host traffic during COMP is ignored
    applyStimulus(1'b1, 1'b1, 8'h7A);
    applyStimulus(1'b1, 1'b1, 8'h7A);
    checkOutput("comp_hold_state", c_state, 3);
    checkOutput("comp_hold_str", str_reg_w, str_abc);
    checkOutput("comp_hold_pat", pat_reg_w, pat_b);
    checkOutput("comp_hold_len", {str_len, pat_len}, {6'd3, 4'd1});

    exp_q.push_back('{1'b1, 5'd1});
    comp_ready = 1'b1;
    comp_match = 1'b1;
    comp_index = 5'd1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    comp_ready = 1'b0;
    checkOutput("out_valid", valid, 1);
    checkOutput("out_state", c_state, 4);
    checkOutput("out_busy", busy, 1);
    checkOutput("out_match", {match, match_index}, {1'b1, 5'd1});
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("after_out_valid", valid, 0);
    checkOutput("after_out_state", c_state, 0);
    checkOutput("after_out_busy", busy, 0);

    // Second pattern "xy" against the same string, comparator reports no match
    applyStimulus(1'b0, 1'b1, 8'h78);
    checkOutput("p2_state", c_state, 2);
    applyStimulus(1'b0, 1'b1, 8'h79);
    exp_pat = '0;
    exp_pat[79:64] = {8'h78, 8'h79};
    checkOutput("p2_pat", pat_reg_w, exp_pat);
    checkOutput("p2_pat_len", pat_len, 2);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("p2_comp_state", c_state, 3);
    checkOutput("p2_str_kept", str_reg_w, str_abc);
    checkOutput("p2_str_len_kept", str_len, 3);
    exp_q.push_back('{1'b0, 5'd0});
    comp_ready = 1'b1;
    comp_match = 1'b0;
    comp_index = 5'd7;
    applyStimulus(1'b0, 1'b0, 8'h00);
    comp_ready = 1'b0;
    checkOutput("nomatch_valid", valid, 1);
    checkOutput("nomatch_result", {match, match_index}, 0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("p2_idle", c_state, 0);
    checkOutput("two_pulses", valid_count, 2);
    checkOutput("p2_str_after", str_reg_w, str_abc);

    // 33 string characters: the last one overflows
    for (int i = 0; i < 33; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h41 + i));
      if (i == 31) begin
        checkOutput("str32_len", str_len, 32);
        checkOutput("str32_ovf", ovf, 0);
      end
    end
    exp_str = '0;
    exp_str[7:0] = 8'h20;
    exp_str[271:264] = 8'h20;
    for (int k = 1; k <= 32; k++) exp_str[8*k +: 8] = 8'(8'h41 + 32 - k);
    checkOutput("str33_len", str_len, 32);
    checkOutput("str33_ovf", ovf, 1);
    checkOutput("str33_reg", str_reg_w, exp_str);
    checkOutput("str33_byte32", str_reg_w[263:256], 8'h41);

    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("str_end_idle", c_state, 0);
    checkOutput("ovf_sticky", ovf, 1);
    applyStimulus(1'b1, 1'b0, 8'h71);
    checkOutput("new_str_ovf_clear", ovf, 0);
    checkOutput("new_str_len", str_len, 1);
    applyStimulus(1'b0, 1'b0, 8'h00);

    // 11 pattern characters: the last one overflows
    exp_pat = '0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'h30 + i));
      if (i < 10) exp_pat[8*(9-i) +: 8] = 8'(8'h30 + i);
      if (i == 9) begin
        checkOutput("pat10_len", pat_len, 10);
        checkOutput("pat10_ovf", ovf, 0);
        checkOutput("pat10_reg", pat_reg_w, exp_pat);
      end
    end
    checkOutput("pat11_len", pat_len, 10);
    checkOutput("pat11_ovf", ovf, 1);
    checkOutput("pat11_reg", pat_reg_w, exp_pat);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("pat11_comp", c_state, 3);

    // Reset during COMP with comp_ready arriving afterwards
    reset = 1'b1;
    #1;
    checkOutput("async_rst_state", c_state, 0);
    checkOutput("async_rst_busy", busy, 0);
    comp_ready = 1'b1;
    comp_match = 1'b1;
    comp_index = 5'd5;
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkResetState();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("post_rst_state", c_state, 0);
    checkOutput("post_rst_valid", valid, 0);
    comp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);

    checkOutput("total_pulses", valid_count, 2);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
